// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: shared constants, state type and digit-count helper for the sequential binary-to-BCD converter
package bin_to_bcd_seq_pkg;
  localparam int BCD_W = 4;
  localparam int ADD3_THRESH = 5;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int min_bcd_digits(input int width);
    longint v;
    int n;
    v = (longint'(1) << width) - 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v > 0) begin
        n++;
        v = v / 10;
      end
    end
    return n < 1 ? 1 : n;
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// bcd_add3_digit: combinational double-dabble corrector, d in -> q = d>=5 ? d+3 : d (4-bit, no carry out)
module bcd_add3_digit
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = d >= BCD_W'(ADD3_THRESH) ? d + BCD_W'(3) : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: one-shift-per-clock double-dabble converter; in clk/rst_n/start/bin, out busy/valid/dig0..dig3/overflow
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int OUT_DIGITS = 4,
  parameter int BCD_DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             valid,
  output logic [3:0]       dig0,
  output logic [3:0]       dig1,
  output logic [3:0]       dig2,
  output logic [3:0]       dig3,
  output logic             overflow
);
  localparam int BW = BCD_DIGITS * BCD_W;
  localparam int OW = OUT_DIGITS * BCD_W;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [BW-1:0] bcd, corr;
  logic [BW:0] sh;
  logic [CW-1:0] cnt;
  logic [OW-1:0] dig;
  logic last;
  if (BCD_DIGITS < min_bcd_digits(WIDTH) || OUT_DIGITS < 4 || OUT_DIGITS >= BCD_DIGITS) begin : g_bad
    $error("bin_to_bcd_seq: BCD_DIGITS too small or OUT_DIGITS out of range");
  end
  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
    bcd_add3_digit u_add3 (.d(bcd[i*BCD_W +: BCD_W]), .q(corr[i*BCD_W +: BCD_W]));
  end
  assign sh = {corr, sr[WIDTH-1]};
  assign last = state == SHIFT && cnt == CW'(WIDTH - 1);
  assign busy = state == SHIFT;
  assign {dig3, dig2, dig1, dig0} = dig[4*BCD_W-1:0];
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr       <= '0;
      bcd      <= '0;
      cnt      <= '0;
      dig      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= last;
      if (state == IDLE && start) begin
        sr  <= bin;
        bcd <= '0;
        cnt <= '0;
      end else if (state == SHIFT) begin
        sr  <= sr << 1;
        bcd <= sh[BW-1:0];
        cnt <= cnt + CW'(1);
      end
      if (last) begin
        dig      <= sh[OW-1:0];
        overflow <= |sh[BW:OW];
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized scoreboard bench for bin_to_bcd_seq against an arithmetic reference model
module tb_bin_to_bcd_seq;
  localparam int WIDTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [WIDTH-1:0] bin = '0;
  logic busy, valid, overflow;
  logic [3:0] dig0, dig1, dig2, dig3;
  int errs = 0;
  int checks = 0;
  bit armed = 1'b0;
  int mcnt = 0;
  bit mvalid = 1'b0;
  bit mrst = 1'b0;
  logic [16:0] q[$];
  logic [16:0] cur = '0;
  bin_to_bcd_seq #(.WIDTH(WIDTH), .OUT_DIGITS(4), .BCD_DIGITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy), .valid(valid),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [16:0] ref_of(input int v);
    logic [3:0] d0, d1, d2, d3;
    d0 = 4'(v % 10);
    d1 = 4'((v / 10) % 10);
    d2 = 4'((v / 100) % 10);
    d3 = 4'((v / 1000) % 10);
    return {d3, d2, d1, d0, v > 9999};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    mrst = !rst_n;
    mvalid = rst_n && mcnt == 1;
    if (!rst_n) begin
      mcnt = 0;
      q.delete();
    end else if (mcnt == 0 && start) begin
      mcnt = WIDTH;
      q.push_back(ref_of(int'(bin)));
    end else if (mcnt > 0) mcnt--;
  end
  always @(negedge clk) begin
    if (armed) begin
      chk("busy", 32'(busy), 32'(mcnt > 0));
      chk("valid", 32'(valid), 32'(mvalid));
      if (mrst) cur = '0;
      if (valid === 1'b1) begin
        if (q.size() == 0) begin
          errs++;
          $display("FAIL scoreboard: valid with no pending conversion at %0t", $time);
        end else cur = q.pop_front();
      end
      chk("result", 32'({dig3, dig2, dig1, dig0, overflow}), 32'(cur));
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic conv(input int v);
    start = 1'b1;
    bin = 16'(v);
    tick(1);
    start = 1'b0;
    bin = 16'($urandom);
    tick(WIDTH + 2);
  endtask
  initial begin
    tick(2);
    rst_n = 1'b1;
    #1 armed = 1'b1;
    chk("reset_digits", 32'({dig3, dig2, dig1, dig0, overflow}), 32'd0);
    chk("reset_busy", 32'({busy, valid}), 32'd0);
    conv(0);
    conv(9999);
    conv(1234);
    conv(10000);
    conv(65535);
    conv(12345);
    start = 1'b1;
    bin = 16'd42;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    bin = 16'd77;
    tick(1);
    start = 1'b0;
    tick(16);
    start = 1'b1;
    bin = 16'd500;
    tick(1);
    start = 1'b0;
    tick(7);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(20);
    conv(500);
    start = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bin = k % 2 == 0 ? 16'd7 : 16'd8;
      tick(WIDTH + 1);
    end
    start = 1'b0;
    tick(WIDTH + 2);
    for (int k = 0; k < 30; k++) begin
      start = 1'b1;
      bin = 16'($urandom_range(0, 65535));
      tick(1);
      start = 1'($urandom_range(0, 1));
      for (int j = 0; j < 20; j++) begin
        bin = 16'($urandom);
        tick(1);
        start = 1'($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      tick(WIDTH + 2);
    end
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
